raster_walker: RTL and testbench

//  Sequential, parametrised triangle rasterizer. It accepts one triangle per handshake
//  and walks its bounding box in raster order using incremental edge functions.
//  For each covered pixel it emits the pixel coordinate and depth-weighted barycentric

---
 rtl/raster_walker.sv | 142 ++++++++++++++
 tb/tb_raster_walker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/raster_walker.sv
// raster_walker: walks a triangle's bounding box with incremental edge functions
// and streams covered pixels with depth-weighted barycentrics.
module raster_walker #(
    parameter int COORD_W = 10,
    parameter int Z_W = 7,
    localparam int EW = 2*COORD_W+1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    // depth factors carry one integer bit so that 1<<Z_W (unity weight) is representable
    input  logic [Z_W:0]       az,
    input  logic [Z_W:0]       bz,
    input  logic [Z_W:0]       cz,
    output logic               frag_valid,
    input  logic               frag_ready,
    output logic [COORD_W-1:0] frag_x,
    output logic [COORD_W-1:0] frag_y,
    output logic [EW-1:0]      frag_uw,
    output logic [EW-1:0]      frag_vw,
    output logic [EW-1:0]      frag_ww,
    output logic [EW+1:0]      frag_aw,
    output logic               busy,
    output logic               done
);
    localparam int ED = 2*COORD_W+3;
    localparam int UW = ED+2;
    localparam int PW = EW+Z_W+1;
    typedef enum logic [1:0] {IDLE, SETUP, WALK, DONE} state_t;
    state_t state, state_n;
    logic [COORD_W-1:0] lax, lay, lbx, lby, lcx, lcy, x, y, xmin, xmax, ymax;
    logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
    logic [Z_W:0] laz, lbz, lcz;
    logic signed [ED-1:0] area, v, w, vr, wr, svx, swx, svy, swy;
    logic signed [ED-1:0] dbx, dby, dcx, dcy, pxo, pyo, s_val, v0, w0;
    logic signed [UW-1:0] u;
    logic [PW-1:0] pu, pv, pw;
    logic neg, cov, last_x, last, adv, ld;

    function automatic logic signed [ED-1:0] ext(input logic [COORD_W-1:0] c);
        return $signed({{(ED-COORD_W){1'b0}}, c});
    endfunction

    always_comb begin
        dbx = ext(lbx) - ext(lax);
        dby = ext(lby) - ext(lay);
        dcx = ext(lcx) - ext(lax);
        dcy = ext(lcy) - ext(lay);
        bx_min = (lax < lbx) ? ((lax < lcx) ? lax : lcx) : ((lbx < lcx) ? lbx : lcx);
        bx_max = (lax > lbx) ? ((lax > lcx) ? lax : lcx) : ((lbx > lcx) ? lbx : lcx);
        by_min = (lay < lby) ? ((lay < lcy) ? lay : lcy) : ((lby < lcy) ? lby : lcy);
        by_max = (lay > lby) ? ((lay > lcy) ? lay : lcy) : ((lby > lcy) ? lby : lcy);
        pxo = ext(bx_min) - ext(lax);
        pyo = ext(by_min) - ext(lay);
        s_val = dbx*dcy - dby*dcx;
        v0 = pxo*dcy - pyo*dcx;
        w0 = dbx*pyo - dby*pxo;
        neg = s_val[ED-1];
        u = UW'(area) - UW'(v) - UW'(w);
        cov = !u[UW-1] && !v[ED-1] && !w[ED-1];
        last_x = x == xmax;
        last = last_x && y == ymax;
        ld = state == WALK && cov && (!frag_valid || frag_ready);
        adv = state == WALK && (!cov || !frag_valid || frag_ready);
        pu = PW'($unsigned(u)) * PW'(laz);
        pv = PW'($unsigned(v)) * PW'(lbz);
        pw = PW'($unsigned(w)) * PW'(lcz);
    end

    always_comb begin
        state_n = state;
        tri_ready = state == IDLE;
        busy = state != IDLE;
        done = 1'b0;
        case (state)
            IDLE:  state_n = tri_valid ? SETUP : IDLE;
            SETUP: state_n = (s_val == '0) ? DONE : WALK;
            WALK:  state_n = (adv && last) ? DONE : WALK;
            DONE: begin
                done = !frag_valid || frag_ready;
                state_n = done ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {lax, lay, lbx, lby, lcx, lcy, laz, lbz, lcz} <= '0;
            {x, y, xmin, xmax, ymax} <= '0;
            {area, v, w, vr, wr, svx, swx, svy, swy} <= '0;
            frag_valid <= 1'b0;
            {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw} <= '0;
        end else begin
            state <= state_n;
            if (tri_valid && tri_ready)
                {lax, lay, lbx, lby, lcx, lcy, laz, lbz, lcz} <= {ax, ay, bx, by, cx, cy, az, bz, cz};
            if (state == SETUP) begin
                {x, y, xmin, xmax, ymax} <= {bx_min, by_min, bx_min, bx_max, by_max};
                area <= neg ? -s_val : s_val;
                v <= neg ? -v0 : v0;
                vr <= neg ? -v0 : v0;
                w <= neg ? -w0 : w0;
                wr <= neg ? -w0 : w0;
                svx <= neg ? -dcy : dcy;
                swx <= neg ? dby : -dby;
                svy <= neg ? dcx : -dcx;
                swy <= neg ? -dbx : dbx;
            end
            // row wrap restarts from the saved row-start edges rather than undoing x steps
            if (adv && last_x) begin
                x <= xmin;
                y <= y + COORD_W'(1);
                v <= vr + svy;
                vr <= vr + svy;
                w <= wr + swy;
                wr <= wr + swy;
            end else if (adv) begin
                x <= x + COORD_W'(1);
                v <= v + svx;
                w <= w + swx;
            end
            frag_valid <= ld || (frag_valid && !frag_ready);
            if (ld) begin
                frag_x <= x;
                frag_y <= y;
                frag_uw <= EW'(pu >> Z_W);
                frag_vw <= EW'(pv >> Z_W);
                frag_ww <= EW'(pw >> Z_W);
                frag_aw <= {2'b0, EW'(pu >> Z_W)} + {2'b0, EW'(pv >> Z_W)} + {2'b0, EW'(pw >> Z_W)};
            end
        end
    end
endmodule

// File: tb/tb_raster_walker.sv
// tb_raster_walker: table-driven triangles checked against a direct edge-function model
// and hand-computed probe pixels, plus stall and mid-walk reset sequences.
module tb_raster_walker;
    localparam int CW = 10;
    localparam int ZW = 7;
    localparam int EW = 2*CW+1;

    logic clk = 0, rst_n = 0, tri_valid = 0, frag_ready = 1;
    logic tri_ready, frag_valid, busy, done;
    logic [CW-1:0] ax = 0, ay = 0, bx = 0, by = 0, cx = 0, cy = 0, frag_x, frag_y;
    logic [ZW:0] az = 0, bz = 0, cz = 0;
    logic [EW-1:0] frag_uw, frag_vw, frag_ww;
    logic [EW+1:0] frag_aw;

    raster_walker #(.COORD_W(CW), .Z_W(ZW)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .az(az), .bz(bz), .cz(cz),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y),
        .frag_uw(frag_uw), .frag_vw(frag_vw), .frag_ww(frag_ww), .frag_aw(frag_aw),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ax, ay, bx, by, cx, cy, az, bz, cz;
        int n;
        int px, py, puw, pvw, pww, paw;
        int done_k, first_k;
    } vec_t;
    typedef struct {int x, y, uw, vw, ww, aw;} frag_t;

    vec_t vecs[6];
    frag_t q[$];
    int tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input vec_t t);
        int s, a, v, w, u, xn, xx, yn, yx;
        frag_t f;
        q.delete();
        s = (t.bx-t.ax)*(t.cy-t.ay) - (t.by-t.ay)*(t.cx-t.ax);
        a = s < 0 ? -s : s;
        xn = t.ax < t.bx ? (t.ax < t.cx ? t.ax : t.cx) : (t.bx < t.cx ? t.bx : t.cx);
        xx = t.ax > t.bx ? (t.ax > t.cx ? t.ax : t.cx) : (t.bx > t.cx ? t.bx : t.cx);
        yn = t.ay < t.by ? (t.ay < t.cy ? t.ay : t.cy) : (t.by < t.cy ? t.by : t.cy);
        yx = t.ay > t.by ? (t.ay > t.cy ? t.ay : t.cy) : (t.by > t.cy ? t.by : t.cy);
        if (s != 0)
            for (int py = yn; py <= yx; py++)
                for (int px = xn; px <= xx; px++) begin
                    v = (px-t.ax)*(t.cy-t.ay) - (py-t.ay)*(t.cx-t.ax);
                    w = (t.bx-t.ax)*(py-t.ay) - (t.by-t.ay)*(px-t.ax);
                    if (s < 0) begin v = -v; w = -w; end
                    u = a - v - w;
                    if (u >= 0 && v >= 0 && w >= 0) begin
                        f.x = px; f.y = py;
                        f.uw = (u*t.az) >> ZW; f.vw = (v*t.bz) >> ZW; f.ww = (w*t.cz) >> ZW;
                        f.aw = f.uw + f.vw + f.ww;
                        q.push_back(f);
                    end
                end
    endtask

    task automatic run(input vec_t t, input int stall_at, input int rst_after);
        int k, got, done_cnt, done_k, first_k, stall_cnt, probe_hit;
        bit fin, aborted;
        frag_t h;
        build(t);
        {k, got, done_cnt, done_k, first_k, stall_cnt, probe_hit} = '0;
        fin = 0; aborted = 0;
        @(negedge clk);
        chk("tri_ready_idle", int'(tri_ready), 1);
        ax = CW'(t.ax); ay = CW'(t.ay); bx = CW'(t.bx); by = CW'(t.by); cx = CW'(t.cx); cy = CW'(t.cy);
        az = (ZW+1)'(t.az); bz = (ZW+1)'(t.bz); cz = (ZW+1)'(t.cz);
        tri_valid = 1; frag_ready = 1;
        while (!fin) begin
            @(negedge clk);
            k++;
            tri_valid = 0;
            if (k == 1) begin
                chk("busy_setup", int'(busy), 1);
                chk("tri_ready_busy", int'(tri_ready), 0);
            end
            frag_ready = !(frag_valid && got == stall_at && stall_cnt < 5);
            if (!frag_ready) begin
                if (stall_cnt == 0) begin
                    h.x = int'(frag_x); h.y = int'(frag_y); h.uw = int'(frag_uw); h.aw = int'(frag_aw);
                end else begin
                    chk("stall_valid", int'(frag_valid), 1);
                    chk("stall_x", int'(frag_x), h.x);
                    chk("stall_y", int'(frag_y), h.y);
                    chk("stall_uw", int'(frag_uw), h.uw);
                    chk("stall_aw", int'(frag_aw), h.aw);
                end
                stall_cnt++;
            end
            #1;
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (frag_valid && first_k == 0) first_k = k;
            if (frag_valid && frag_ready) begin
                if (got < q.size()) begin
                    chk("frag_x", int'(frag_x), q[got].x);
                    chk("frag_y", int'(frag_y), q[got].y);
                    chk("frag_uw", int'(frag_uw), q[got].uw);
                    chk("frag_vw", int'(frag_vw), q[got].vw);
                    chk("frag_ww", int'(frag_ww), q[got].ww);
                    chk("frag_aw", int'(frag_aw), q[got].aw);
                end else chk("extra_frag", got, q.size()-1);
                if (int'(frag_x) == t.px && int'(frag_y) == t.py) begin
                    probe_hit++;
                    chk("probe_uw", int'(frag_uw), t.puw);
                    chk("probe_vw", int'(frag_vw), t.pvw);
                    chk("probe_ww", int'(frag_ww), t.pww);
                    chk("probe_aw", int'(frag_aw), t.paw);
                end
                got++;
                if (got == rst_after) begin
                    rst_n = 0;
                    #1;
                    chk("rst_frag_valid", int'(frag_valid), 0);
                    chk("rst_tri_ready", int'(tri_ready), 1);
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_done", int'(done), 0);
                    @(negedge clk);
                    rst_n = 1;
                    aborted = 1;
                    fin = 1;
                end
            end
            if (done_k != 0 && k >= done_k + 2) fin = 1;
            if (k > 3000) begin
                chk("timeout", k, 0);
                fin = 1;
            end
        end
        if (!aborted) begin
            chk("frag_count", got, t.n);
            chk("done_pulses", done_cnt, 1);
            chk("tri_ready_back", int'(tri_ready), 1);
            chk("frag_valid_idle", int'(frag_valid), 0);
            if (t.px >= 0) chk("probe_seen", probe_hit, 1);
            if (stall_at < 0 && t.done_k > 0) chk("done_latency", done_k, t.done_k);
            if (t.first_k > 0) chk("first_latency", first_k, t.first_k);
            if (stall_at >= 0) chk("stall_cycles", stall_cnt, 5);
        end
    endtask

    initial begin
        vecs[0] = '{0,0, 4,0, 0,4, 128,128,128, 15, 1,1, 8,4,4,16, 27, 3};
        vecs[1] = '{0,0, 0,4, 4,0, 128,128,128, 15, 3,0, 4,0,12,16, 27, 3};
        vecs[2] = '{0,0, 2,2, 4,4, 128,128,128, 0, -1,-1, 0,0,0,0, 2, 0};
        vecs[3] = '{0,0, 4,0, 0,4, 64,128,32, 15, 1,1, 4,4,1,9, 27, 3};
        vecs[4] = '{5,5, 7,5, 5,7, 128,128,128, 6, 6,5, 2,2,0,4, 11, 3};
        vecs[5] = '{0,0, 3,0, 0,1, 128,128,128, 5, 2,0, 1,2,0,3, 10, 3};
        repeat (2) @(negedge clk);
        chk("reset_tri_ready", int'(tri_ready), 1);
        chk("reset_frag_valid", int'(frag_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_frag_aw", int'(frag_aw), 0);
        chk("reset_frag_x", int'(frag_x), 0);
        rst_n = 1;
        for (int i = 0; i < 6; i++) run(vecs[i], -1, -1);
        run(vecs[0], 2, -1);
        run(vecs[0], -1, 6);
        run(vecs[1], -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
